// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: register offsets inside the
// address window, TCTL bit positions and the register-select type used by
// the address decoder.
package interval_timer_pkg;

  // Byte offsets of the registers relative to the base address.
  localparam int unsigned TCNT_OFF = 0;
  localparam int unsigned TLIM_OFF = 2;
  localparam int unsigned TCTL_OFF = 4;

  // TCTL bit positions.
  localparam int unsigned TCTL_READY_BIT = 0;
  localparam int unsigned TCTL_OVR_BIT   = 2;
  localparam int unsigned TCTL_IE_BIT    = 8;

  // Which register (if any) the current bus address selects.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TCNT,
    SEL_TLIM,
    SEL_TCTL
  } reg_sel_e;

  // Map a window offset to a register select; anything else is a non-hit.
  function automatic reg_sel_e decode_offset(input logic [31:0] off);
    reg_sel_e sel;
    case (off)
      TCNT_OFF: sel = SEL_TCNT;
      TLIM_OFF: sel = SEL_TLIM;
      TCTL_OFF: sel = SEL_TCTL;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/interval_timer_if.sv
// MEM-stage data bus as seen by the interval timer: address, write data and
// the read/write strobes. The processor side uses the master modport, the
// timer uses the slave modport. Read data (RBUS) is a tri-state net and stays
// a plain inout port on the timer itself.
interface interval_timer_if #(
  parameter int unsigned ABITS = 16,
  parameter int unsigned DBITS = 16
) ();

  logic [ABITS-1:0] ABUS;
  logic [DBITS-1:0] WBUS;
  logic             RE;
  logic             WE;

  modport master (
    output ABUS,
    output WBUS,
    output RE,
    output WE
  );

  modport slave (
    input ABUS,
    input WBUS,
    input RE,
    input WE
  );

endinterface

// File: rtl/interval_timer_tick_divider.sv
// Prescaler for the interval timer. Counts 0..DIVN-1 and wraps; tick is high
// for the single cycle in which the count sits at DIVN-1. A synchronous clear
// restarts the count at 0 (used when software reloads TCNT).
module interval_timer_tick_divider #(
  parameter int unsigned DIVN = 10000,
  parameter int unsigned DIVB = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [DIVB-1:0] P_LAST = DIVB'(DIVN - 1);
  localparam logic [DIVB-1:0] P_ONE  = DIVB'(1);

  logic [DIVB-1:0] p_q;
  logic [DIVB-1:0] p_d;

  assign tick = (p_q == P_LAST);

  // Next prescaler value: clear has priority, otherwise count and wrap.
  always_comb begin
    // NOTE: default assignment first so every path drives p_d and no latch is inferred.
    p_d = p_q + P_ONE;
    if (clr || tick) begin
      p_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Memory-mapped interval timer on the MEM-stage data bus.
//   RBASE+0 : TCNT  tick counter (write reloads it and restarts the prescaler)
//   RBASE+2 : TLIM  wrap limit (0 = free-running counter, never wraps)
//   RBASE+4 : TCTL  bit0 READY, bit2 OVR, bit8 IE
// Reads are combinational from ABUS/RE; writes land on the CLK edge.
// INTR = IE & READY.
// Build option: define TIMER_OVERRUN_EN to implement the OVR flag; without it
// TCTL bit2 reads 0, writes to it are ignored and a wrap while READY is
// already set is simply lost.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int unsigned      ABITS = 16,
  parameter int unsigned      DBITS = 16,
  parameter logic [ABITS-1:0] RBASE = ABITS'(16'hFFE0),
  parameter int unsigned      DIVN  = 10000,
  parameter int unsigned      DIVB  = 14
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  interval_timer_if.slave       bus,
  inout  wire  [DBITS-1:0]      RBUS,
  output logic                  INTR
);

  localparam logic [DBITS-1:0] ONE = DBITS'(1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ABITS-1:0] offset;
  reg_sel_e         sel;
  logic             wr_tcnt;
  logic             wr_tlim;
  logic             wr_tctl;

  assign offset  = bus.ABUS - RBASE;
  assign sel     = decode_offset(32'(offset));
  assign wr_tcnt = bus.WE && (sel == SEL_TCNT);
  assign wr_tlim = bus.WE && (sel == SEL_TLIM);
  assign wr_tctl = bus.WE && (sel == SEL_TCTL);

  // ---------------------------------------------------------------------------
  // Prescaler: a TCNT reload restarts the tick period from zero.
  // ---------------------------------------------------------------------------
  logic tick;

  interval_timer_tick_divider #(
    .DIVN (DIVN),
    .DIVB (DIVB)
  ) u_tick_divider (
    .clk   (CLK),
    .rst_n (RSTN),
    .clr   (wr_tcnt),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [DBITS-1:0] tcnt_q, tcnt_d;
  logic [DBITS-1:0] tlim_q, tlim_d;
  logic             ready_q, ready_d;
  logic             ie_q, ie_d;
  logic             wrap;

  // A wrap happens on a tick when a limit is set and the count has reached
  // TLIM-1 (or beyond, after TLIM was lowered). A TCNT write in the same
  // cycle wins outright, so it suppresses the wrap. The compare always uses
  // the TLIM value from before any same-cycle TLIM write.
  assign wrap = tick && !wr_tcnt && (tlim_q != '0) && (tcnt_q >= (tlim_q - ONE));

  // Next-state for TCNT, TLIM, READY and IE.
  always_comb begin
    tcnt_d  = tcnt_q;
    tlim_d  = tlim_q;
    ready_d = ready_q;
    ie_d    = ie_q;

    if (wr_tcnt) begin
      tcnt_d = bus.WBUS;
    end else if (tick) begin
      tcnt_d = wrap ? '0 : (tcnt_q + ONE);
    end

    if (wr_tlim) begin
      tlim_d = bus.WBUS;
    end

    if (wr_tctl) begin
      ie_d = bus.WBUS[TCTL_IE_BIT];
      // Writing 0 clears READY; writing 1 leaves it alone.
      if (!bus.WBUS[TCTL_READY_BIT]) begin
        ready_d = 1'b0;
      end
    end

    // A wrap in the same cycle as a clearing write keeps READY set.
    if (wrap) begin
      ready_d = 1'b1;
    end
  end

  // Timer registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tcnt_q  <= '0;
      tlim_q  <= '0;
      ready_q <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tlim_q  <= tlim_d;
      ready_q <= ready_d;
      ie_q    <= ie_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun flag (optional)
  // ---------------------------------------------------------------------------
`ifdef TIMER_OVERRUN_EN
  logic ovr_q, ovr_d;

  // OVR clears on a 0 write and is set by a wrap that finds READY still set;
  // the set wins over a same-cycle clear.
  always_comb begin
    ovr_d = ovr_q;
    if (wr_tctl && !bus.WBUS[TCTL_OVR_BIT]) begin
      ovr_d = 1'b0;
    end
    if (wrap && ready_q) begin
      ovr_d = 1'b1;
    end
  end

  // Overrun register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end
`else
  logic ovr_q;

  assign ovr_q = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path and interrupt
  // ---------------------------------------------------------------------------
  logic [DBITS-1:0] rd_data;
  logic             rd_en;

  // Select the addressed register for the read bus.
  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_TCNT: rd_data = tcnt_q;
      SEL_TLIM: rd_data = tlim_q;
      SEL_TCTL: begin
        rd_data[TCTL_READY_BIT] = ready_q;
        rd_data[TCTL_OVR_BIT]   = ovr_q;
        rd_data[TCTL_IE_BIT]    = ie_q;
      end
      default:  rd_data = '0;
    endcase
  end

  // Only drive the shared read bus for a read that hits one of our registers.
  assign rd_en = bus.RE && (sel != SEL_NONE);
  assign RBUS  = rd_en ? rd_data : 'z;

  // Level interrupt straight from flops, so it cannot glitch.
  assign INTR = ie_q & ready_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer (DIVN=4, DIVB=2). A directed vector
// table walks the documented timeline, hand sequences cover async reset, and a
// randomized phase is checked against a behavioural model.
module tb_interval_timer;

  localparam int unsigned DIVN = 4;
  localparam int unsigned DIVB = 2;

  localparam logic [15:0] A_TCNT = 16'hFFE0;
  localparam logic [15:0] A_TLIM = 16'hFFE2;
  localparam logic [15:0] A_TCTL = 16'hFFE4;
  localparam logic [15:0] A_HOLE = 16'hFFE1;
  localparam logic [15:0] A_OUT  = 16'hFFF0;
  localparam logic [15:0] Z_PAT  = 16'hA5C3;

`ifdef TIMER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  localparam logic [15:0] CTL_OVR = OVR_EN ? 16'h0105 : 16'h0101;

  logic        clk;
  logic        rst_n;
  logic        intr;
  logic        tb_drv;
  wire  [15:0] rbus;

  interval_timer_if #(.ABITS(16), .DBITS(16)) bus_if ();

  // Bench-side weak stand-in for "nobody drives": a known pattern that is
  // only enabled when the timer is expected to release the bus.
  assign rbus = tb_drv ? Z_PAT : 'z;

  interval_timer #(
    .ABITS (16),
    .DBITS (16),
    .RBASE (16'hFFE0),
    .DIVN  (DIVN),
    .DIVB  (DIVB)
  ) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (bus_if),
    .RBUS (rbus),
    .INTR (intr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the register file
  // ---------------------------------------------------------------------------
  int unsigned m_p, m_tcnt, m_tlim;
  bit          m_ready, m_ovr, m_ie;

  task automatic model_reset();
    m_p = 0; m_tcnt = 0; m_tlim = 0;
    m_ready = 0; m_ovr = 0; m_ie = 0;
  endtask

  function automatic logic [15:0] model_ctl();
    return {7'b0, m_ie, 5'b0, m_ovr, 1'b0, m_ready};
  endfunction

  // One CLK edge with the given bus write (we=0 for reads/idle).
  task automatic model_step(input bit we, input logic [15:0] a, input logic [15:0] d);
    bit          tick, w_cnt, w_lim, w_ctl, wrapped;
    int unsigned n_p, n_tcnt, n_tlim;
    bit          n_ready, n_ovr, n_ie;
    tick    = (m_p == DIVN - 1);
    w_cnt   = we && (a == A_TCNT);
    w_lim   = we && (a == A_TLIM);
    w_ctl   = we && (a == A_TCTL);
    wrapped = tick && !w_cnt && (m_tlim != 0) && (m_tcnt + 1 >= m_tlim);
    n_p     = w_cnt ? 0 : (m_p + 1) % DIVN;
    if (w_cnt)        n_tcnt = d;
    else if (wrapped) n_tcnt = 0;
    else if (tick)    n_tcnt = (m_tcnt + 1) % 65536;
    else              n_tcnt = m_tcnt;
    n_tlim  = w_lim ? d : m_tlim;
    n_ie    = w_ctl ? d[8] : m_ie;
    n_ready = (w_ctl && !d[0]) ? 1'b0 : m_ready;
    n_ovr   = (w_ctl && !d[2]) ? 1'b0 : m_ovr;
    if (wrapped) begin
      if (m_ready) n_ovr = 1'b1;
      n_ready = 1'b1;
    end
    if (!OVR_EN) n_ovr = 1'b0;
    m_p = n_p; m_tcnt = n_tcnt; m_tlim = n_tlim;
    m_ready = n_ready; m_ovr = n_ovr; m_ie = n_ie;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: one record per clock cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        tb_drv;
    logic [15:0] exp_rbus;
    logic        exp_intr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v_wr(input logic [15:0] a, input logic [15:0] d, input logic i);
    return '{we: 1'b1, re: 1'b0, addr: a, wdata: d, tb_drv: 1'b0, exp_rbus: 16'h0, exp_intr: i};
  endfunction

  function automatic vec_t v_rd(input logic [15:0] a, input logic [15:0] e, input logic i);
    return '{we: 1'b0, re: 1'b1, addr: a, wdata: 16'h0, tb_drv: 1'b0, exp_rbus: e, exp_intr: i};
  endfunction

  function automatic vec_t v_z(input logic [15:0] a, input logic r, input logic i);
    return '{we: 1'b0, re: r, addr: a, wdata: 16'h0, tb_drv: 1'b1, exp_rbus: Z_PAT, exp_intr: i};
  endfunction

  task automatic bus_idle();
    bus_if.WE   = 1'b0;
    bus_if.RE   = 1'b0;
    bus_if.ABUS = 16'h0000;
    bus_if.WBUS = 16'h0000;
    tb_drv      = 1'b0;
  endtask

  // Combinational read while the clock is irrelevant (used around reset).
  task automatic rd_now(input logic [15:0] a, input logic [15:0] e, input string name);
    bus_if.RE   = 1'b1;
    bus_if.ABUS = a;
    #1;
    check(name, rbus, e);
    bus_if.RE = 1'b0;
  endtask

  // One cycle of bus activity checked at the falling edge.
  task automatic cycle_rd(input logic [15:0] a, input logic [15:0] e, input string name);
    bus_if.RE   = 1'b1;
    bus_if.ABUS = a;
    @(negedge clk);
    check(name, rbus, e);
    check({name, " intr"}, intr, 1'b0);
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  int          op, k;
  logic [15:0] a, d;
  bit          we_r, re_r, hit;
  logic [15:0] ev;

  initial begin
    rst_n = 1'b0;
    bus_idle();

    // Cycle rows: write TLIM=3 and IE, watch the first wrap at edge 12,
    // second wrap (overrun), clears, TCNT reload on a tick edge, and a
    // READY-clear coinciding with a wrap.
    vecs.push_back(v_wr(A_TLIM, 16'h0003, 0));
    vecs.push_back(v_wr(A_TCTL, 16'h0100, 0));
    vecs.push_back(v_rd(A_TCNT, 16'h0000, 0));
    vecs.push_back(v_rd(A_TCNT, 16'h0000, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(v_rd(A_TCNT, 16'h0001, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(v_rd(A_TCNT, 16'h0002, 0));
    vecs.push_back(v_rd(A_TCNT, 16'h0000, 1));
    vecs.push_back(v_rd(A_TCTL, 16'h0101, 1));
    vecs.push_back(v_z(A_OUT, 1'b1, 1));
    vecs.push_back(v_z(A_HOLE, 1'b1, 1));
    vecs.push_back(v_z(A_TCTL, 1'b0, 1));
    for (int i = 0; i < 7; i++) vecs.push_back(v_rd(A_TLIM, 16'h0003, 1));
    vecs.push_back(v_rd(A_TCTL, CTL_OVR, 1));
    vecs.push_back(v_wr(A_TCTL, 16'h0100, 1));
    vecs.push_back(v_rd(A_TCTL, 16'h0100, 0));
    vecs.push_back(v_wr(A_TCNT, 16'h0002, 0));
    vecs.push_back(v_rd(A_TCNT, 16'h0002, 0));
    vecs.push_back(v_rd(A_TCNT, 16'h0002, 0));
    vecs.push_back(v_rd(A_TLIM, 16'h0003, 0));
    vecs.push_back(v_wr(A_TCTL, 16'h0100, 0));
    vecs.push_back(v_rd(A_TCTL, 16'h0101, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(v_rd(A_TCNT, 16'h0000, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(v_rd(A_TCNT, 16'h0001, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(v_rd(A_TCNT, 16'h0002, 1));
    vecs.push_back(v_wr(A_TCTL, 16'h0100, 1));
    vecs.push_back(v_rd(A_TCTL, CTL_OVR, 1));

    // Reset state.
    @(posedge clk);
    #1;
    check("reset intr", intr, 1'b0);
    rd_now(A_TCNT, 16'h0000, "reset tcnt");
    rd_now(A_TLIM, 16'h0000, "reset tlim");
    rd_now(A_TCTL, 16'h0000, "reset tctl");
    tb_drv = 1'b1;
    rd_now(A_OUT, Z_PAT, "reset nohit z");
    tb_drv = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Apply the directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.WE   = vecs[i].we;
      bus_if.RE   = vecs[i].re;
      bus_if.ABUS = vecs[i].addr;
      bus_if.WBUS = vecs[i].wdata;
      tb_drv      = vecs[i].tb_drv;
      @(negedge clk);
      if (vecs[i].re || vecs[i].tb_drv) begin
        check($sformatf("vec%0d rbus", i), rbus, vecs[i].exp_rbus);
      end
      check($sformatf("vec%0d intr", i), intr, vecs[i].exp_intr);
      @(posedge clk);
      #1;
      bus_idle();
    end

    // Async reset pulse mid-cycle while INTR is high.
    check("pre-reset intr", intr, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset intr", intr, 1'b0);
    rd_now(A_TCNT, 16'h0000, "async reset tcnt");
    rd_now(A_TLIM, 16'h0000, "async reset tlim");
    rd_now(A_TCTL, 16'h0000, "async reset tctl");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle_rd(A_TCNT, 16'h0000, "post-release tcnt");
    cycle_rd(A_TLIM, 16'h0000, "post-release tlim");
    cycle_rd(A_TCTL, 16'h0000, "post-release tctl");

    // Randomized phase against the model, from a fresh reset.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 7);
      case (k)
        0, 1:    a = A_TCNT;
        2, 3:    a = A_TLIM;
        4, 5:    a = A_TCTL;
        6:       a = ($urandom_range(0, 1) != 0) ? A_HOLE : 16'hFFE6;
        default: a = ($urandom_range(0, 1) != 0) ? A_OUT : 16'h1234;
      endcase
      if (a == A_TLIM)      d = 16'($urandom_range(0, 6));
      else if (a == A_TCNT) d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8));
      else                  d = 16'($urandom);
      we_r = (op >= 5) && (op <= 7);
      re_r = (op <= 4);
      hit  = (a == A_TCNT) || (a == A_TLIM) || (a == A_TCTL);
      if (a == A_TCNT)      ev = 16'(m_tcnt);
      else if (a == A_TLIM) ev = 16'(m_tlim);
      else if (a == A_TCTL) ev = model_ctl();
      else                  ev = Z_PAT;

      bus_if.WE   = we_r;
      bus_if.RE   = re_r;
      bus_if.ABUS = a;
      bus_if.WBUS = d;
      tb_drv      = re_r && !hit;
      @(negedge clk);
      if (re_r) begin
        check($sformatf("rand%0d read %h", i, a), rbus, ev);
      end
      check($sformatf("rand%0d intr", i), intr, m_ie & m_ready);
      @(posedge clk);
      model_step(we_r, a, d);
      #1;
      bus_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Memory-mapped interval timer on the processor's MEM-stage data bus (ABUS/RBUS/WBUS/RE/WE), alongside the display, LED, key and switch devices. It divides CLK into ticks, counts ticks in TCNT up to a programmable limit TLIM, latches a READY flag on each wrap and raises INTR to the processor's interrupt request logic. The processor reads it in the same cycle it drives ABUS (combinational RBUS) and writes it on the following CLK edge.

## Interface
- ABITS, 16: bus address width
- DBITS, 16: bus data width
- RBASE, 16'hFFE0: base address; TCNT at RBASE+0, TLIM at RBASE+2, TCTL at RBASE+4
- DIVN, 10000: CLK cycles per tick (≥2)
- DIVB, 14: prescaler counter width; must satisfy 2^DIVB ≥ DIVN

- CLK  in  1  clock, all state on posedge
- RSTN  in  1  reset, asynchronous, active-low
- ABUS  in  ABITS  byte address from MEM stage
- RBUS  inout  DBITS  read data; driven only when RE and address hits a register, else all Z
- RE  in  1  read enable (LW in MEM stage)
- WBUS  in  DBITS  write data
- WE  in  1  write enable (SW in MEM stage)
- INTR  out  1  interrupt request, level

## Operation
- Prescaler P (DIVB bits): counts 0..DIVN-1, wraps to 0; tick asserted for one cycle when P==DIVN-1.
- On tick: if TLIM==0, TCNT<=TCNT+1 (mod 2^DBITS, never wraps by limit). If TLIM!=0 and TCNT ≥ TLIM-1: TCNT<=0, READY<=1, and if READY already 1, OVR<=1. Otherwise TCNT<=TCNT+1.
- TCTL: bit0 READY, bit2 OVR, bit8 IE; other bits read 0.
- Writes (WE, address hit, posedge CLK): TCNT<=WBUS and P<=0; TLIM<=WBUS (TCNT untouched; lowering below TCNT wraps on next tick); TCTL: IE<=WBUS[8]; writing 0 to bit0 clears READY, 1 has no effect; same for bit2/OVR.
- Reads: RBUS = addressed register value, combinational from ABUS/RE; unmapped addresses in the window and non-hits drive Z.
- INTR = IE & READY.
- Simultaneous events: TCNT write in a tick cycle → written value wins, no increment, no wrap. READY-clear write in the wrap cycle → READY stays 1, OVR unchanged by the clear (set rule still applies). TLIM write in tick cycle → compare uses old TLIM.

## Timing
- Reset (RSTN low, async): TCNT=0, TLIM=0, P=0, READY=0, OVR=0, IE=0, INTR=0, RBUS=Z. Release takes effect on first posedge with RSTN high.
- Read latency 0 cycles (same-cycle combinational); write visible to reads the cycle after the WE edge.
- READY/INTR rise on the edge that wraps TCNT; first wrap after reset with TLIM=L occurs after L·DIVN cycles.
- INTR falls the cycle after a clearing write or IE=0 write.
- Reset mid-count discards P and all registers; no INTR glitch on deassert.

## Configuration
- TIMER_OVERRUN_EN defined: OVR bit implemented as above.
- Undefined: OVR flop absent, TCTL bit2 reads 0, writes to it ignored; wrap with READY=1 is silently lost.

## Structure
- Shared package: register offsets (TCNT_OFF=0, TLIM_OFF=2, TCTL_OFF=4), TCTL bit positions (READY=0, OVR=2, IE=8).
- One sub-module: tick_divider (P counter, DIVN/DIVB parameters, clear input, tick output).

## Test plan
- DIVN=4, TLIM=3, IE=1 after reset → READY and INTR rise exactly 12 cycles after TLIM write; TCNT reads 0,0,0,0,1,...,2,0.
- Read TCTL with READY=1, IE=1, OVR=0 → RBUS=16'h0101; non-hit address (16'hFFF0) → timer drives Z.
- Leave READY set through a second wrap → OVR=1, TCTL reads 16'h0105; write 16'h0100 → reads 16'h0100, INTR low next cycle (without TIMER_OVERRUN_EN: reads 16'h0101 then 16'h0100).
- Write TCNT=16'h0002 in the same cycle as a tick with TLIM=3 → TCNT reads 2 next cycle, no wrap, READY unchanged.
- Clearing write to READY in the wrap cycle → READY remains 1, INTR stays high.
- Pulse RSTN low mid-count with INTR high → INTR, TCNT, TLIM, TCTL read 0 immediately and after release.
